// File: rtl/exmemwb_skid_stage.sv
// EX/MEM-to-WB pipeline buffer with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and registered writeback-data select. Optional: EXMEMWB_STALL_CNT_EN.
module exmemwb_skid_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 6,
  parameter int unsigned CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_mem_res,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_mem_res,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [RD_W-1:0]   out_rd,
`ifdef EXMEMWB_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic [DATA_W-1:0] out_wb_data
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state_q, state_d;

  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_mem_q, skid_mem_q;
  logic [DATA_W-1:0] main_alu_q, skid_alu_q;
  logic [RD_W-1:0]   main_rd_q, skid_rd_q;
  logic [DATA_W-1:0] main_wb_q, skid_wb_q;

  logic accept, consume;
  logic ld_main_in, ld_main_skid, ld_skid_in;
  logic [DATA_W-1:0] in_wb;

  // ALUtoReg (ctrl bit1) selects the writeback source at write time.
  assign in_wb = in_ctrl[1] ? in_alu_res : in_mem_res;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid_in   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          ld_main_in = 1'b1;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (consume && accept) begin
          ld_main_in = 1'b1;
        end else if (consume) begin
          state_d = EMPTY;
        end else if (accept) begin
          ld_skid_in = 1'b1;
          state_d    = FULL;
        end
      end
      FULL: begin
        if (consume) begin
          ld_main_skid = 1'b1;
          state_d      = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d      = EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid_in   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_mem_q  <= '0;
      main_alu_q  <= '0;
      main_rd_q   <= '0;
      main_wb_q   <= '0;
      skid_ctrl_q <= '0;
      skid_mem_q  <= '0;
      skid_alu_q  <= '0;
      skid_rd_q   <= '0;
      skid_wb_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ld_main_in) begin
        main_ctrl_q <= in_ctrl;
        main_mem_q  <= in_mem_res;
        main_alu_q  <= in_alu_res;
        main_rd_q   <= in_rd;
        main_wb_q   <= in_wb;
      end else if (ld_main_skid) begin
        main_ctrl_q <= skid_ctrl_q;
        main_mem_q  <= skid_mem_q;
        main_alu_q  <= skid_alu_q;
        main_rd_q   <= skid_rd_q;
        main_wb_q   <= skid_wb_q;
      end
      if (ld_skid_in) begin
        skid_ctrl_q <= in_ctrl;
        skid_mem_q  <= in_mem_res;
        skid_alu_q  <= in_alu_res;
        skid_rd_q   <= in_rd;
        skid_wb_q   <= in_wb;
      end
    end
  end

  // Bubbles must never assert RegWrt or Jm.
  assign out_ctrl    = out_valid ? main_ctrl_q : '0;
  assign out_mem_res = main_mem_q;
  assign out_alu_res = main_alu_q;
  assign out_rd      = main_rd_q;
  assign out_wb_data = main_wb_q;

`ifdef EXMEMWB_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_exmemwb_skid_stage.sv
// Scoreboard bench for exmemwb_skid_stage: a queue models the buffered entries,
// every cycle checks handshake, gating and head payload. Honours EXMEMWB_STALL_CNT_EN.
module tb_exmemwb_skid_stage;

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [5:0]  rd;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [2:0]  in_ctrl, out_ctrl;
  logic [31:0] in_mem_res, in_alu_res, out_mem_res, out_alu_res, out_wb_data;
  logic [5:0]  in_rd, out_rd;
`ifdef EXMEMWB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  ent_t        sb[$];
  ent_t        cur;
  int unsigned nvec = 0;
  int unsigned nerr = 0;
  int unsigned stall_m = 0;

  always #5 clk = ~clk;

  exmemwb_skid_stage #(.DATA_W(32), .RD_W(6), .CTRL_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ctrl     (in_ctrl),
    .in_mem_res  (in_mem_res),
    .in_alu_res  (in_alu_res),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ctrl    (out_ctrl),
    .out_mem_res (out_mem_res),
    .out_alu_res (out_alu_res),
    .out_rd      (out_rd),
`ifdef EXMEMWB_STALL_CNT_EN
    .stall_cnt   (stall_cnt),
`endif
    .out_wb_data (out_wb_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input ent_t e);
    cur        = e;
    in_valid   = v;
    in_ctrl    = e.ctrl;
    in_mem_res = e.mem;
    in_alu_res = e.alu;
    in_rd      = e.rd;
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    e.ctrl = 3'($urandom());
    e.mem  = $urandom();
    e.alu  = $urandom();
    e.rd   = 6'($urandom());
    return e;
  endfunction

  // Called mid-cycle with inputs set; checks outputs, advances the model over one edge.
  task automatic step(output bit acc);
    bit   exp_vld, exp_rdy, con;
    ent_t h;
    #1;
    exp_vld = (sb.size() > 0);
    exp_rdy = (sb.size() < 2);
    chk("out_valid", out_valid, exp_vld);
    chk("in_ready", in_ready, exp_rdy);
    if (!exp_vld) begin
      chk("ctrl_gate", out_ctrl, 0);
    end else begin
      h = sb[0];
      chk("out_ctrl", out_ctrl, h.ctrl);
      chk("out_mem", out_mem_res, h.mem);
      chk("out_alu", out_alu_res, h.alu);
      chk("out_rd", out_rd, h.rd);
      chk("out_wb", out_wb_data, h.ctrl[1] ? h.alu : h.mem);
    end
`ifdef EXMEMWB_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, stall_m);
`endif
    acc = in_valid && exp_rdy && !rst && !flush;
    con = exp_vld && out_ready;
    if (rst) begin
      sb.delete();
      stall_m = 0;
    end else begin
      if (exp_vld && !out_ready && stall_m != 16'hFFFF) stall_m++;
      if (con) void'(sb.pop_front());
      if (flush) sb.delete();
      else if (acc) sb.push_back(cur);
    end
    @(negedge clk);
  endtask

  task automatic send(input ent_t e);
    bit a;
    int n;
    n = 0;
    drive(1'b1, e);
    do begin
      step(a);
      n++;
    end while (!a && n < 50);
    chk("send_timeout", a, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit a;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step(a);
  endtask

  initial begin
    bit   a;
    int   n;
    ent_t e;

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    e = rnd_ent();
    drive(1'b1, e);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_wb", out_wb_data, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_rd", out_rd, 0);
    step(a);
    rst = 1'b0;
    in_valid = 1'b0;
    idle(1);

    // Back-to-back streaming at full throughput
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      e.ctrl = 3'b011; e.mem = $urandom(); e.alu = 32'(i); e.rd = 6'(i);
      send(e);
    end
    idle(3);

    // Skid: A, B fill the buffer, C waits upstream
    out_ready = 1'b0;
    e.ctrl = 3'b001; e.mem = 32'hAAAA0000; e.alu = 32'h1111; e.rd = 6'd1;
    send(e);
    e.ctrl = 3'b011; e.mem = 32'hBBBB0000; e.alu = 32'h2222; e.rd = 6'd2;
    send(e);
    e.ctrl = 3'b101; e.mem = 32'hCCCC0000; e.alu = 32'h3333; e.rd = 6'd3;
    drive(1'b1, e);
    for (int i = 0; i < 3; i++) step(a);
    #1 chk("skid_a_wb", out_wb_data, 32'hAAAA0000);
    out_ready = 1'b1;
    n = 0;
    do begin
      step(a);
      n++;
    end while (!a && n < 20);
    chk("skid_c_accept", a, 1);
    in_valid = 1'b0;
    idle(4);

    // Flush while FULL with a live input in the same cycle
    out_ready = 1'b0;
    send(rnd_ent());
    send(rnd_ent());
    e = rnd_ent();
    e.ctrl = 3'b111;
    drive(1'b1, e);
    flush = 1'b1;
    step(a);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(4);

    // Consume and accept together in ONE
    out_ready = 1'b0;
    e = rnd_ent(); e.rd = 6'd5;
    send(e);
    out_ready = 1'b1;
    e = rnd_ent(); e.rd = 6'd9;
    send(e);
    out_ready = 1'b0;
    #1;
    chk("ca_rd", out_rd, 9);
    chk("ca_in_ready", in_ready, 1);
    idle(1);
    out_ready = 1'b1;
    idle(2);

    // Random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), rnd_ent());
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      step(a);
    end
    flush = 1'b0;
    out_ready = 1'b1;
    idle(4);

`ifdef EXMEMWB_STALL_CNT_EN
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    out_ready = 1'b0;
    send(rnd_ent());
    idle(10);
    #1 chk("stall_ten", stall_cnt, 10);
    out_ready = 1'b1;
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(2);
    #1 chk("stall_flush_keep", stall_cnt, 10);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    #1 chk("stall_rst_clear", stall_cnt, 0);
    idle(1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/exmemwb_skid_stage.md
Name: exmemwb_skid_stage

Overview:
- Parametrised EXandMEM/WB pipeline buffer: the generalised successor to the fixed-width EX/MEM-to-WB register.
- Carries writeback control, memory result, ALU result and destination register address from EXandMEM to WB.
- Adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure from WB stalls the stage without dropping or duplicating an instruction.
- Adds synchronous flush and a registered, precomputed writeback data select.

Parameters:
DATA_W, 32, width of mem_res, alu_res and wb_data
RD_W, 6, width of destination register address
CTRL_W, 3, width of control bundle; bit0 = RegWrt, bit1 = ALUtoReg, bit2 = Jm, bits above 2 passed through untouched

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
flush  input  1  synchronous kill of all buffered entries
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry this cycle
in_ctrl  input  CTRL_W  control bundle
in_mem_res  input  DATA_W  memory read data
in_alu_res  input  DATA_W  ALU result
in_rd  input  RD_W  write register address
out_valid  output  1  head entry valid toward WB
out_ready  input  1  WB consumes head entry this cycle
out_ctrl  output  CTRL_W  head control; forced to 0 when out_valid=0
out_mem_res  output  DATA_W  head memory data
out_alu_res  output  DATA_W  head ALU result
out_rd  output  RD_W  head register address
out_wb_data  output  DATA_W  registered writeback data: alu_res if ALUtoReg=1, else mem_res

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset: all outputs 0 after the first rising edge with rst=1, except in_ready=1. State goes to EMPTY and the skid register is cleared. rst has priority over flush and over all handshakes.
- Storage: main register (drives outputs) plus skid register. wb_data is computed when the entry is written into either register, never combinationally at the output.
- Transfers: accept = in_valid & in_ready; consume = out_valid & out_ready.
- in_ready = (state != FULL). It is a registered state decode with no combinational path from out_ready.
- EMPTY (out_valid=0):
  - accept -> main <= in, go to ONE.
- ONE (out_valid=1):
  - consume & !accept -> EMPTY.
  - consume & accept -> main <= in, stay ONE (full throughput, latency 1 cycle).
  - !consume & accept -> skid <= in, go to FULL.
  - neither -> hold.
- FULL (out_valid=1, in_ready=0):
  - consume -> main <= skid, go to ONE.
  - otherwise hold. Upstream data is ignored while in_ready=0.
- Latency: an entry accepted at edge N is visible at the outputs after edge N when the stage was EMPTY, or when it was ONE with a consume. Ordering is strictly FIFO.
- flush=1 at an edge: state <= EMPTY, both valids cleared. Any same-cycle accept is discarded; a same-cycle consume is still counted by WB as consumed. The next cycle gives out_valid=0, out_ctrl=0, in_ready=1.
- Control gating: out_ctrl is 0 whenever out_valid=0, so a bubble never asserts RegWrt or Jm.
- Payload when out_valid=0: data outputs hold their last value (don't-care).
- Widths: no arithmetic. All fields are copied bit-exact. wb_data selection uses ctrl bit1 of the entry being written.

Optional Feature:
- Macro: EXMEMWB_STALL_CNT_EN.
- When defined:
  - extra output port stall_cnt, 16 bits.
  - Increments each cycle with out_valid=1 and out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by rst; not cleared by flush.
- When undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, out_wb_data=0, in_ready=1. First accept only happens after rst drops.
- Streaming: out_ready=1; issue 4 back-to-back entries alu_res=1,2,3,4 with ctrl=3'b011 -> out_alu_res=1..4 on consecutive cycles, 1-cycle latency, out_wb_data equals alu_res.
- Skid: out_ready=0; send A (mem_res=0xAAAA0000, ctrl=3'b001) then B -> in_ready falls after B. Third entry C is held upstream. Raise out_ready -> A, B, C emerge in order; out_wb_data of A = 0xAAAA0000.
- Flush with FULL stage: assert flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1. Neither the buffered entries nor the flushed-cycle input ever appear.
- Simultaneous consume+accept in ONE: head rd=5, input rd=9 -> next cycle out_rd=9, state ONE, no skid use.
- With EXMEMWB_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 10 cycles -> stall_cnt=10. A flush leaves it at 10; rst clears it to 0.
